// File: rtl/leds_racer_pkg.sv
// Shared definitions for the WS2812 LED line of the racer core.
// Both the line transmitter and the stream receiver import this package so
// that pulse timing, pixel layout and receiver state encoding agree.
//
// Contents:
//   T0H_CLK / T1H_CLK / BIT_PERIOD_CLK : transmit pulse timing in clk cycles
//   RESET_GAP_CLK                      : low time that latches a frame
//   BIT_THRESHOLD_DEF / MAX_HIGH_DEF   : receiver decode limits
//   PIXEL_W, GRB_FIELD_W, *_OFS        : 24-bit GRB word layout
//   rx_state_e                         : receiver state encoding
package leds_racer_pkg;

  localparam int T0H_CLK        = 20;
  localparam int T1H_CLK        = 40;
  localparam int BIT_PERIOD_CLK = 62;
  localparam int RESET_GAP_CLK  = 2500;

  localparam int BIT_THRESHOLD_DEF = 30;
  localparam int MAX_HIGH_DEF      = 100;

  localparam int GRB_FIELD_W = 8;
  localparam int PIXEL_W     = 3 * GRB_FIELD_W;
  localparam int G_OFS       = 16;
  localparam int R_OFS       = 8;
  localparam int B_OFS       = 0;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Input conditioning for the WS2812 receiver.
// Brings the asynchronous LED line into the clk domain through two flops and
// registers the synchronized value once more so that rising and falling
// edges can be flagged for a single cycle.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   din   : raw line, asynchronous to clk
//   din_s : synchronized line level
//   rise  : din_s went 0 -> 1 this cycle
//   fall  : din_s went 1 -> 0 this cycle
module ws2812_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic din_m;
  logic din_d;

  // Two-stage synchronizer followed by a delay stage used only for edge
  // detection; the line idles low so every stage resets to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_d <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812_stream_rx.sv
// WS2812 serial stream receiver.
// Measures high-pulse widths on the LED line, decodes them into bits,
// assembles 24-bit GRB pixels (first bit received lands in bit 23) and tags
// each pixel with its position in the frame. A long low gap latches the
// frame; malformed traffic is reported on bit_error.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   leds_line      : raw WS2812 line
//   pixel_grb      : last decoded pixel, G[23:16] R[15:8] B[7:0]
//   pixel_index    : LED index of pixel_grb within the current frame
//   pixel_valid    : one-cycle strobe, pixel_grb/pixel_index are new
//   frame_end      : one-cycle strobe on a latch gap that followed pixels
//   bit_error      : one-cycle strobe on a protocol error
//   frame_overflow : sticky until the next latch, frame had too many pixels
module ws2812_stream_rx
  import leds_racer_pkg::*;
#(
  parameter int BIT_THRESHOLD_CLK = BIT_THRESHOLD_DEF,
  parameter int MAX_HIGH_CLK      = MAX_HIGH_DEF,
  parameter int RESET_CLK         = RESET_GAP_CLK,
  parameter int MAX_POS           = 109
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         leds_line,
  output logic [PIXEL_W-1:0]           pixel_grb,
  output logic [$clog2(MAX_POS+1)-1:0] pixel_index,
  output logic                         pixel_valid,
  output logic                         frame_end,
  output logic                         bit_error,
  output logic                         frame_overflow
);

  localparam int IDX_W  = $clog2(MAX_POS + 1);
  localparam int NXT_W  = $clog2(MAX_POS + 2);
  localparam int LOW_W  = $clog2(RESET_CLK + 1);
  localparam int HIGH_W = $clog2(MAX_HIGH_CLK + 2);

  localparam logic [LOW_W-1:0]  LOW_FULL = LOW_W'(RESET_CLK);
  localparam logic [LOW_W-1:0]  LOW_LAST = LOW_W'(RESET_CLK - 1);
  localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(MAX_HIGH_CLK);
  localparam logic [HIGH_W-1:0] HIGH_ONE = HIGH_W'(BIT_THRESHOLD_CLK);
  localparam logic [NXT_W-1:0]  NXT_MAX  = NXT_W'(MAX_POS);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(MAX_POS);
  localparam logic [4:0]        LAST_BIT = 5'(PIXEL_W - 1);

  rx_state_e            state_q;
  rx_state_e            state_d;
  logic                 din_s;
  logic                 rise;
  logic                 fall;
  logic [LOW_W-1:0]     low_cnt;
  logic [HIGH_W-1:0]    high_cnt;
  logic [4:0]           bit_cnt;
  logic [PIXEL_W-2:0]   shift_reg;
  logic [NXT_W-1:0]     next_idx;
  logic                 bit_val;
  logic                 frame_start;
  logic                 latch;
  logic                 hi_error;

  ws2812_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (leds_line),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  assign bit_val = (high_cnt >= HIGH_ONE);

  // Next-state logic. Each *_LAST comparison fires on the cycle the low
  // counter steps onto RESET_CLK, so the latch happens once per gap and not
  // again while the counter sits saturated. The over-long pulse check comes
  // before the falling-edge decode so an error always wins.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    latch       = 1'b0;
    hi_error    = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (!din_s && low_cnt == LOW_LAST) begin
          state_d     = LOW;
          frame_start = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (low_cnt == LOW_LAST) begin
          latch = 1'b1;
        end
      end
      HIGH: begin
        if (high_cnt > HIGH_MAX) begin
          state_d  = SYNC;
          hi_error = 1'b1;
        end else if (fall) begin
          state_d = LOW;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Datapath and output registers. next_idx counts pixels reported in this
  // frame and stops at MAX_POS+1; pixel_index follows it one cycle late and
  // saturated, so during a pixel_valid strobe it still shows that pixel's
  // index. The 24th bit is merged straight into pixel_grb so the strobe
  // appears on the cycle after the decoded falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SYNC;
      low_cnt        <= '0;
      high_cnt       <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      next_idx       <= '0;
      pixel_grb      <= '0;
      pixel_index    <= '0;
      pixel_valid    <= 1'b0;
      frame_end      <= 1'b0;
      bit_error      <= 1'b0;
      frame_overflow <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      bit_error   <= 1'b0;
      pixel_index <= (next_idx > NXT_MAX) ? IDX_MAX : next_idx[IDX_W-1:0];
      unique case (state_q)
        SYNC: begin
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_cnt != LOW_FULL) begin
            low_cnt <= low_cnt + 1'b1;
          end
          if (frame_start) begin
            bit_cnt     <= '0;
            next_idx    <= '0;
            pixel_index <= '0;
          end
        end
        LOW: begin
          if (rise) begin
            low_cnt  <= '0;
            high_cnt <= '0;
          end else if (low_cnt != LOW_FULL) begin
            low_cnt <= low_cnt + 1'b1;
          end
          if (latch) begin
            bit_error      <= (bit_cnt != 5'd0);
            frame_end      <= (next_idx != '0);
            bit_cnt        <= '0;
            next_idx       <= '0;
            pixel_index    <= '0;
            frame_overflow <= 1'b0;
          end
        end
        HIGH: begin
          if (hi_error) begin
            bit_error <= 1'b1;
            bit_cnt   <= '0;
            low_cnt   <= '0;
          end else if (fall) begin
            low_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (next_idx <= NXT_MAX) begin
                pixel_grb   <= {shift_reg, bit_val};
                pixel_valid <= 1'b1;
                next_idx    <= next_idx + 1'b1;
              end else begin
                frame_overflow <= 1'b1;
              end
            end else begin
              shift_reg <= {shift_reg[PIXEL_W-3:0], bit_val};
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            high_cnt <= high_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_stream_rx.sv
// Testbench for ws2812_stream_rx: drives WS2812 waveforms on leds_line and
// compares the decoded pixel stream with the pixels the bench itself sent.
module tb_ws2812_stream_rx;

  localparam int MAX_POS = 109;
  localparam int GAP_CLK = 2530;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        leds_line;
  logic [23:0] pixel_grb;
  logic [6:0]  pixel_index;
  logic        pixel_valid;
  logic        frame_end;
  logic        bit_error;
  logic        frame_overflow;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cnt      = 0;
  int be_cnt      = 0;

  int hi0, lo0, hi1, lo1;

  logic [23:0] got_grb[$];
  int          got_idx[$];
  logic [23:0] exp_grb[$];
  int          exp_idx[$];

  ws2812_stream_rx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .leds_line      (leds_line),
    .pixel_grb      (pixel_grb),
    .pixel_index    (pixel_index),
    .pixel_valid    (pixel_valid),
    .frame_end      (frame_end),
    .bit_error      (bit_error),
    .frame_overflow (frame_overflow)
  );

  always #5 clk = ~clk;

  // Collects every strobe the receiver produces.
  always @(negedge clk) begin
    if (pixel_valid) begin
      got_grb.push_back(pixel_grb);
      got_idx.push_back(int'(pixel_index));
    end
    if (frame_end) fe_cnt++;
    if (bit_error) be_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Nominal line timing (period 62) or a short timing for long frames.
  task automatic setTiming(input bit compact);
    if (compact) begin
      hi0 = 5;  lo0 = 3;  hi1 = 33; lo1 = 3;
    end else begin
      hi0 = 20; lo0 = 42; hi1 = 40; lo1 = 22;
    end
  endtask

  task automatic sendBit(input logic b);
    leds_line = 1'b1;
    repeat (b ? hi1 : hi0) @(negedge clk);
    leds_line = 1'b0;
    repeat (b ? lo1 : lo0) @(negedge clk);
  endtask

  // Sends the top nbits of grb, MSB first.
  task automatic applyStimulus(input logic [23:0] grb, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) sendBit(grb[i]);
  endtask

  task automatic gap();
    leds_line = 1'b0;
    repeat (GAP_CLK) @(negedge clk);
  endtask

  task automatic expectPixel(input logic [23:0] grb, input int idx);
    exp_grb.push_back(grb);
    exp_idx.push_back(idx);
  endtask

  task automatic checkPixels(input string tag);
    @(posedge clk); #1;
    checkOutput({tag, "_count"}, got_grb.size(), exp_grb.size());
    for (int i = 0; i < exp_grb.size() && i < got_grb.size(); i++) begin
      checkOutput($sformatf("%s_grb%0d", tag, i), 32'(got_grb[i]), 32'(exp_grb[i]));
      checkOutput($sformatf("%s_idx%0d", tag, i), got_idx[i], exp_idx[i]);
    end
    got_grb.delete();
    got_idx.delete();
    exp_grb.delete();
    exp_idx.delete();
  endtask

  task automatic mark(output int fe0, output int be0);
    @(posedge clk); #1;
    fe0 = fe_cnt;
    be0 = be_cnt;
  endtask

  initial begin
    logic [23:0] px;
    int fe0, be0;

    rst_n     = 1'b0;
    leds_line = 1'b0;
    setTiming(1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_grb", 32'(pixel_grb), 0);
    checkOutput("rst_index", 32'(pixel_index), 0);
    checkOutput("rst_valid", 32'(pixel_valid), 0);
    checkOutput("rst_frame_end", 32'(frame_end), 0);
    checkOutput("rst_bit_error", 32'(bit_error), 0);
    checkOutput("rst_overflow", 32'(frame_overflow), 0);
    rst_n = 1'b1;
    gap();
    mark(fe0, be0);

    $display("[TB] single pixel 0xFF0000");
    applyStimulus(24'hFF0000, 24);
    expectPixel(24'hFF0000, 0);
    gap();
    checkPixels("t1");
    checkOutput("t1_frame_end", fe_cnt - fe0, 1);
    checkOutput("t1_bit_error", be_cnt - be0, 0);
    mark(fe0, be0);

    $display("[TB] three pixels with latency on last bit");
    applyStimulus(24'h123456, 24);
    expectPixel(24'h123456, 0);
    applyStimulus(24'hABCDEF, 24);
    expectPixel(24'hABCDEF, 1);
    applyStimulus(24'h000001, 23);
    expectPixel(24'h000001, 2);
    leds_line = 1'b1;
    repeat (hi1) @(negedge clk);
    leds_line = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("t2_valid_at_2", 32'(pixel_valid), 0);
    @(posedge clk); #1;
    checkOutput("t2_valid_at_3", 32'(pixel_valid), 1);
    checkOutput("t2_grb_at_3", 32'(pixel_grb), 32'h000001);
    checkOutput("t2_index_at_3", 32'(pixel_index), 2);
    @(negedge clk);
    gap();
    checkPixels("t2");
    checkOutput("t2_frame_end", fe_cnt - fe0, 1);
    checkOutput("t2_bit_error", be_cnt - be0, 0);
    mark(fe0, be0);

    $display("[TB] truncated pixel then gap");
    setTiming(1'b1);
    applyStimulus(24'($urandom), 12);
    gap();
    checkPixels("t3a");
    checkOutput("t3_bit_error", be_cnt - be0, 1);
    checkOutput("t3_no_frame_end", fe_cnt - fe0, 0);
    px = 24'($urandom);
    applyStimulus(px, 24);
    expectPixel(px, 0);
    gap();
    checkPixels("t3b");
    checkOutput("t3_frame_end", fe_cnt - fe0, 1);
    mark(fe0, be0);

    $display("[TB] over-long high pulse");
    px = 24'($urandom);
    applyStimulus(px, 24);
    expectPixel(px, 0);
    applyStimulus(24'($urandom), 10);
    leds_line = 1'b1;
    repeat (150) @(negedge clk);
    leds_line = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    checkOutput("t4_bit_error", be_cnt - be0, 1);
    applyStimulus(24'($urandom), 24);
    gap();
    px = 24'($urandom);
    applyStimulus(px, 24);
    expectPixel(px, 0);
    gap();
    checkPixels("t4");
    checkOutput("t4_frame_end", fe_cnt - fe0, 1);
    checkOutput("t4_bit_error_total", be_cnt - be0, 1);
    mark(fe0, be0);

    $display("[TB] frame of %0d pixels", MAX_POS + 2);
    for (int i = 0; i <= MAX_POS; i++) begin
      px = 24'($urandom) & 24'h800001;
      applyStimulus(px, 24);
      expectPixel(px, i);
    end
    repeat (5) @(negedge clk);
    checkOutput("t5_overflow_full", 32'(frame_overflow), 0);
    checkOutput("t5_index_full", 32'(pixel_index), MAX_POS);
    applyStimulus(24'($urandom) & 24'h800001, 24);
    repeat (5) @(negedge clk);
    checkOutput("t5_overflow_set", 32'(frame_overflow), 1);
    checkOutput("t5_index_sat", 32'(pixel_index), MAX_POS);
    gap();
    checkPixels("t5");
    checkOutput("t5_overflow_clr", 32'(frame_overflow), 0);
    checkOutput("t5_index_clr", 32'(pixel_index), 0);
    checkOutput("t5_frame_end", fe_cnt - fe0, 1);
    checkOutput("t5_bit_error", be_cnt - be0, 0);
    mark(fe0, be0);

    $display("[TB] reset mid-pixel");
    px = 24'($urandom) | 24'h800000;
    applyStimulus(px, 24);
    expectPixel(px, 0);
    applyStimulus(24'($urandom), 8);
    leds_line = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_grb_async", 32'(pixel_grb), 0);
    checkOutput("t6_index_async", 32'(pixel_index), 0);
    checkOutput("t6_valid_async", 32'(pixel_valid), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    leds_line = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(24'($urandom), 24);
    gap();
    px = 24'($urandom);
    applyStimulus(px, 24);
    expectPixel(px, 0);
    gap();
    checkPixels("t6");
    checkOutput("t6_frame_end", fe_cnt - fe0, 1);
    checkOutput("t6_bit_error", be_cnt - be0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
